keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans the 3x3 whack-a-mole keypad matrix and debounces presses.
- Emits the packed 4-bit key code {col[1:0], row[1:0]} consumed by the key decoder; e.g. col 1 / row 0 = 4'b0100, which decodes to key 1.
- Sits between the board keypad pins and the game FSM's key decoder, driving columns and sensing rows.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1.
- REPEAT_SCANS, 25, full scans between auto-repeat pulses (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- row_sense  input  3  keypad row lines, active-low, asynchronous to clk
- col_drive  output  3  keypad column drive, one-hot active-low
- key_code  output  4  {col[1:0], row[1:0]} of the accepted key; 4'b1111 when no key is accepted
- key_valid  output  1  one-cycle pulse when key_code is newly accepted
- key_held  output  1  high while the accepted key remains debounced-pressed

Behaviour:
- Reset: everything is synchronous to clk; reset is synchronous, active-high.
  - Reset values: col_drive=3'b110, key_code=4'b1111, key_valid=0, key_held=0.
  - Internal state clears: column index=0, dwell counter=0, synchronizer=3'b111, match/repeat counters=0, FSM=IDLE.
- Reset mid-operation: all of the above take effect the cycle after reset is sampled high. No key_valid is emitted during or on exit from reset.
- Row input: row_sense passes through a 2-flop synchronizer. "Pressed" means the synchronized bit is 0.
- Scan timing:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, the synchronized rows for the current column are captured into a 9-bit snapshot at bit row*3+col.
  - The column then advances 0->1->2->0, and col_drive updates on the same edge.
  - A full scan is 3*SCAN_DIV cycles. The scan ends on column 2's capture.
- Scan candidate: computed at each scan end as the lowest set snapshot bit index n, encoded {col=n%3, row=n/3}. If no bit is set, the candidate is NONE. Simultaneous presses therefore resolve to the lowest key number. The snapshot clears for the next scan.
- FSM (evaluated once per scan end):
  - IDLE:
    - Candidate not NONE -> DEBOUNCE, latch the candidate, match=1.
    - If DEBOUNCE_SCANS=1, go directly to the accept action below.
  - DEBOUNCE:
    - Candidate equals latched -> match++.
    - Candidate differs but is not NONE -> relatch, match=1.
    - NONE -> IDLE.
    - When match reaches DEBOUNCE_SCANS, accept:
      - key_code<=latched, key_valid=1 for one cycle, key_held=1, go to HELD.
  - HELD:
    - Candidate NONE -> RELEASE, match=1.
    - Any other candidate, including a different key, is ignored; there is no rollover.
  - RELEASE:
    - NONE -> match++.
    - Any non-NONE candidate -> back to HELD, match=0.
    - When match reaches DEBOUNCE_SCANS: key_held=0, key_code=4'b1111, go to IDLE.
- Latency: key_valid asserts 1 cycle after the scan end that completes debounce. key_code is stable from that cycle until release.
- Width rules: match and repeat counters saturate at their parameter widths ($clog2(param+1)). Code values 4'b0011, 4'b0111, 4'b1011 and 4'b11xx are never produced except the idle value 4'b1111.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter increments each scan end.
  - On reaching REPEAT_SCANS, key_valid pulses again with the same key_code and the counter clears.
  - The counter clears on entry to HELD.
- Undefined: exactly one key_valid per accepted press. The REPEAT_SCANS logic is absent.

Decomposition:
- Package wam_key_pkg holds:
  - NO_KEY_CODE=4'b1111, NUM_COLS=3, NUM_ROWS=3.
  - FSM state enum typedef (IDLE, DEBOUNCE, HELD, RELEASE).
  - Pack function {col,row} -> code.
- Sub-module key_col_scan: the dwell counter, column index, col_drive, and the scan_end/capture strobes. keypad_scanner keeps the synchronizer, snapshot, priority pick and FSM.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3; a full scan = 12 cycles):
- Reset then no press for 5 scans -> col_drive cycles 110,101,011 every 4 cycles; key_code=1111; key_valid never high.
- Hold col 1/row 0 for 3 scans -> after the 2nd matching scan end, key_code=4'b0100 and a single key_valid pulse; key_held=1. Decoder output=1.
- Press col 2/row 2 plus col 0/row 1 together -> key_code=4'b0001 (key 3, the lowest wins).
- 1-scan glitch on col 0/row 0, then release -> no key_valid, key_code stays 1111.
- Hold key 4, release for 1 scan, re-press, then release for 2 scans -> one key_valid only; key_held drops after 2 clean scans; key_code=1111.
- Reset asserted mid-DEBOUNCE, or with KEYPAD_REPEAT_EN defined and key 8 held for 10 scans:
  - Reset case -> outputs return to reset values; no pulse.
  - Repeat case -> key_valid pulses at accept and then every 3 scans, with key_code=4'b1010.

Source files
------------

// File: rtl/wam_key_pkg.sv
// Shared keypad definitions: matrix geometry, idle key code, scanner FSM states
// and the {col,row} key-code packing used by the scanner and the key decoder.
package wam_key_pkg;

  localparam logic [3:0] NO_KEY_CODE = 4'b1111;
  localparam int         NUM_COLS    = 3;
  localparam int         NUM_ROWS    = 3;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } key_state_e;

  function automatic logic [3:0] pack_code(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_col_scan.sv
// Column scan timebase: dwells SCAN_DIV cycles on each column, drives the
// active-low one-hot column lines and flags the capture / scan-end cycles.
module key_col_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] col_drive_o,
  output logic [1:0] col_idx_o,
  output logic       capture_o,
  output logic       scan_end_o
);
  import wam_key_pkg::*;

  localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [1:0]      COL_LAST   = 2'(NUM_COLS - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;

  // The last dwell cycle of a column is both its capture cycle and the
  // cycle on whose closing edge the next column starts being driven.
  always_comb begin
    capture_o  = (dwell_q == DWELL_LAST);
    scan_end_o = capture_o && (col_q == COL_LAST);
    dwell_d    = capture_o ? '0 : dwell_q + 1'b1;
    col_d      = col_q;
    if (capture_o) begin
      col_d = (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
      col_q   <= 2'd0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    col_drive_o = 3'b110;
    case (col_q)
      2'd0:    col_drive_o = 3'b110;
      2'd1:    col_drive_o = 3'b101;
      2'd2:    col_drive_o = 3'b011;
      default: col_drive_o = 3'b110;
    endcase
  end

  assign col_idx_o = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 keypad scanner with per-scan debounce of press and release.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_SCANS scans while held.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] row_sense,
  output logic [2:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  import wam_key_pkg::*;

  localparam int            MW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_SCANS);
  localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

  logic [2:0]  sync1_q, sync2_q;
  logic [8:0]  snap_q, snap_d, snap_full;
  logic [3:0]  cand;
  logic [1:0]  col_idx;
  logic        capture, scan_end;

  key_state_e    state_q, state_d;
  logic [3:0]    latched_q, latched_d;
  logic [MW-1:0] match_q, match_d, match_inc;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_SCANS;
`endif

  key_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_col_scan (
    .clk        (clk),
    .reset      (reset),
    .col_drive_o(col_drive),
    .col_idx_o  (col_idx),
    .capture_o  (capture),
    .scan_end_o (scan_end)
  );

  // The capture of the final column is folded in combinationally so the
  // candidate at scan end sees the complete scan.
  always_comb begin
    snap_full = snap_q;
    if (capture) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!sync2_q[r]) begin
          snap_full[r*NUM_COLS + int'(col_idx)] = 1'b1;
        end
      end
    end
    snap_d = scan_end ? 9'd0 : snap_full;
  end

  // Descending walk so the lowest pressed key number ends up as the candidate.
  always_comb begin
    cand = NO_KEY_CODE;
    for (int n = 8; n >= 0; n--) begin
      if (snap_full[n]) begin
        cand = pack_code(2'(n % NUM_COLS), 2'(n / NUM_COLS));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    match_d   = match_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    match_inc = (match_q == '1) ? match_q : match_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
    rep_inc   = (rep_q == '1) ? rep_q : rep_q + 1'b1;
`endif
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (cand != NO_KEY_CODE) begin
            state_d   = DEBOUNCE;
            latched_d = cand;
            match_d   = MATCH_ONE;
          end
        end
        DEBOUNCE: begin
          if (cand == NO_KEY_CODE) begin
            state_d = IDLE;
            match_d = '0;
          end else if (cand == latched_q) begin
            match_d = match_inc;
          end else begin
            latched_d = cand;
            match_d   = MATCH_ONE;
          end
        end
        HELD: begin
          if (cand == NO_KEY_CODE) begin
            state_d = RELEASE;
            match_d = MATCH_ONE;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc >= REP_DONE) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
        RELEASE: begin
          if (cand != NO_KEY_CODE) begin
            state_d = HELD;
            match_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            match_d = match_inc;
          end
        end
        default: begin
          state_d = IDLE;
          match_d = '0;
        end
      endcase

      // Completion is checked on the next-state values so a single-scan
      // debounce accepts or releases in the same scan it starts.
      if ((state_d == DEBOUNCE) && (match_d >= MATCH_DONE)) begin
        code_d  = latched_d;
        valid_d = 1'b1;
        held_d  = 1'b1;
        state_d = HELD;
        match_d = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      if ((state_d == RELEASE) && (match_d >= MATCH_DONE)) begin
        code_d  = NO_KEY_CODE;
        held_d  = 1'b0;
        state_d = IDLE;
        match_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      snap_q    <= 9'd0;
      state_q   <= IDLE;
      latched_q <= NO_KEY_CODE;
      match_q   <= '0;
      code_q    <= NO_KEY_CODE;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      sync1_q   <= row_sense;
      sync2_q   <= sync1_q;
      snap_q    <= snap_d;
      state_q   <= state_d;
      latched_q <= latched_d;
      match_q   <= match_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a scan-level behavioural model of the
// keypad and debouncer is compared against the DUT on every cycle.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DS   = 2;
  localparam int RS   = 3;
  localparam int SCAN = 3 * SD;

  localparam int P_IDLE    = 0;
  localparam int P_PENDING = 1;
  localparam int P_DOWN    = 2;
  localparam int P_UP      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] row_sense;
  logic [2:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [8:0] pressedMask = 9'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dutPulses = 0;
  bit checkEn = 1'b0;

  int         phase = P_IDLE;
  int         agree = 0;
  int         repCount = 0;
  logic [3:0] latched = 4'hF;
  logic [3:0] expCode = 4'hF;
  logic       expValid = 1'b0;
  logic       expHeld = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DS),
    .REPEAT_SCANS  (RS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_sense(row_sense),
    .col_drive(col_drive),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Physical matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row_sense = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressedMask[r*3 + c] && !col_drive[c]) row_sense[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] lowestKey(input logic [8:0] m);
    logic [3:0] code;
    bit         found;
    code  = 4'hF;
    found = 1'b0;
    for (int n = 0; n < 9; n++) begin
      if (m[n] && !found) begin
        code  = {2'(n % 3), 2'(n / 3)};
        found = 1'b1;
      end
    end
    return code;
  endfunction

  task automatic modelScanEnd(input logic [3:0] cand);
    bool_step: begin
      if (phase == P_IDLE) begin
        if (cand != 4'hF) begin
          latched = cand;
          agree   = 1;
          phase   = P_PENDING;
        end
      end else if (phase == P_PENDING) begin
        if (cand == 4'hF) begin
          phase = P_IDLE;
          agree = 0;
        end else if (cand == latched) begin
          agree = agree + 1;
        end else begin
          latched = cand;
          agree   = 1;
        end
      end else if (phase == P_DOWN) begin
        if (cand == 4'hF) begin
          phase = P_UP;
          agree = 1;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          repCount = repCount + 1;
          if (repCount >= RS) begin
            expValid = 1'b1;
            repCount = 0;
          end
`endif
        end
      end else begin
        if (cand != 4'hF) begin
          phase    = P_DOWN;
          agree    = 0;
          repCount = 0;
        end else begin
          agree = agree + 1;
        end
      end
    end
    if (phase == P_PENDING && agree >= DS) begin
      expCode  = latched;
      expValid = 1'b1;
      expHeld  = 1'b1;
      phase    = P_DOWN;
      agree    = 0;
      repCount = 0;
    end
    if (phase == P_UP && agree >= DS) begin
      expCode = 4'hF;
      expHeld = 1'b0;
      phase   = P_IDLE;
      agree   = 0;
    end
  endtask

  // Model advances on the same edges as the DUT; cyc indexes cycles since reset.
  always @(posedge clk) begin
    expValid = 1'b0;
    if (reset) begin
      cyc      = 0;
      phase    = P_IDLE;
      agree    = 0;
      repCount = 0;
      latched  = 4'hF;
      expCode  = 4'hF;
      expHeld  = 1'b0;
      checkEn  = 1'b1;
    end else begin
      if (cyc % SCAN == SCAN - 1) modelScanEnd(lowestKey(pressedMask));
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0] expDrive;
    if (checkEn) begin
      expDrive = 3'b111 & ~(3'b001 << ((cyc / SD) % 3));
      checkOutput("col_drive", {5'd0, col_drive}, {5'd0, expDrive});
      checkOutput("key_code", {4'd0, key_code}, {4'd0, expCode});
      checkOutput("key_valid", {7'd0, key_valid}, {7'd0, expValid});
      checkOutput("key_held", {7'd0, key_held}, {7'd0, expHeld});
      if (key_valid) dutPulses++;
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [8:0] mask, input int scans);
    pressedMask = mask;
    repeat (scans * SCAN) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int expPulses;
    logic [8:0] m;

    doReset();
    checkOutput("reset_code", {4'd0, key_code}, 8'h0F);
    checkOutput("reset_drive", {5'd0, col_drive}, 8'h06);

    // Idle keypad for five scans.
    applyStimulus(9'd0, 5);
    checkOutput("idle_pulses", dutPulses[7:0], 8'd0);
    checkOutput("idle_code", {4'd0, key_code}, 8'h0F);

    // Key 1 (col 1 / row 0) held for three scans, then released.
    base = dutPulses;
    applyStimulus(9'h002, 3);
    checkOutput("key1_code", {4'd0, key_code}, 8'h04);
    checkOutput("key1_model_code", {4'd0, expCode}, 8'h04);
    checkOutput("key1_held", {7'd0, key_held}, 8'd1);
    checkOutput("key1_pulses", 8'(dutPulses - base), 8'd1);
    applyStimulus(9'd0, 2);
    checkOutput("key1_release_code", {4'd0, key_code}, 8'h0F);
    checkOutput("key1_release_held", {7'd0, key_held}, 8'd0);

    // Keys 8 and 3 together: the lower key wins.
    applyStimulus(9'h108, 2);
    checkOutput("multi_code", {4'd0, key_code}, 8'h01);
    checkOutput("multi_valid", {7'd0, key_valid}, 8'd1);
    applyStimulus(9'd0, 2);

    // One-scan glitch on key 0 must not be accepted.
    base = dutPulses;
    applyStimulus(9'h001, 1);
    applyStimulus(9'd0, 2);
    checkOutput("glitch_pulses", 8'(dutPulses - base), 8'd0);
    checkOutput("glitch_code", {4'd0, key_code}, 8'h0F);

    // Key 4 with a one-scan release bounce, then a clean release.
    base = dutPulses;
    applyStimulus(9'h010, 2);
    applyStimulus(9'd0, 1);
    applyStimulus(9'h010, 1);
    checkOutput("bounce_held", {7'd0, key_held}, 8'd1);
    checkOutput("bounce_code", {4'd0, key_code}, 8'h05);
    applyStimulus(9'd0, 2);
    checkOutput("bounce_pulses", 8'(dutPulses - base), 8'd1);
    checkOutput("bounce_release_held", {7'd0, key_held}, 8'd0);
    checkOutput("bounce_release_code", {4'd0, key_code}, 8'h0F);

    // Reset while key 2 is mid-debounce.
    base = dutPulses;
    applyStimulus(9'h004, 1);
    repeat (5) @(posedge clk);
    doReset();
    checkOutput("midrst_code", {4'd0, key_code}, 8'h0F);
    checkOutput("midrst_valid", {7'd0, key_valid}, 8'd0);
    checkOutput("midrst_held", {7'd0, key_held}, 8'd0);
    checkOutput("midrst_drive", {5'd0, col_drive}, 8'h06);
    applyStimulus(9'd0, 3);
    checkOutput("midrst_pulses", 8'(dutPulses - base), 8'd0);

    // Key 8 held for ten scans.
    base = dutPulses;
    applyStimulus(9'h100, 10);
    checkOutput("key8_code", {4'd0, key_code}, 8'h0A);
    applyStimulus(9'd0, 2);
`ifdef KEYPAD_REPEAT_EN
    expPulses = 3;
`else
    expPulses = 1;
`endif
    checkOutput("key8_pulses", 8'(dutPulses - base), 8'(expPulses));

    // Random press patterns held for a few scans each.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       m = 9'd0;
        1, 2:    m = 9'd1 << $urandom_range(0, 8);
        default: m = (9'd1 << $urandom_range(0, 8)) | (9'd1 << $urandom_range(0, 8));
      endcase
      applyStimulus(m, $urandom_range(1, 3));
    end
    applyStimulus(9'd0, 3);
    checkOutput("final_code", {4'd0, key_code}, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
